// File: rtl/load_value_counter.sv
// Free-running WIDTH-bit up-counter with a synchronous parallel load.
// Wrap pulses for one cycle when an increment rolls Count from all-ones to zero.
module load_value_counter #(
   parameter int WIDTH       = 4,
   parameter int RESET_VALUE = 0
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Load_Value_Valid,
   input  logic [WIDTH-1:0] Load_Value,
   output logic [WIDTH-1:0] Count,
   output logic             Wrap
);

   localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] count_reg, count_next;
   logic             wrap_reg,  wrap_next;

   // A load takes priority over the increment and never produces Wrap,
   // even when the outgoing count is all-ones.
   always_comb begin
      count_next = count_reg + WIDTH'(1);
      wrap_next  = &count_reg;
      if (Load_Value_Valid) begin
         count_next = Load_Value;
         wrap_next  = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         count_reg <= RESET_COUNT;
         wrap_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         wrap_reg  <= wrap_next;
      end
   end

   assign Count = count_reg;
   assign Wrap  = wrap_reg;

endmodule

// File: tb/tb_load_value_counter.sv
// Self-checking bench: directed scenarios then random load/reset traffic,
// each edge compared against an arithmetic model of the counter.
module tb_load_value_counter;

   localparam int WIDTH = 4;
   localparam int MOD   = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             load_valid = 1'b0;
   logic [WIDTH-1:0] load_value = '0;
   logic [WIDTH-1:0] count;
   logic             wrap;

   int checks = 0;
   int errors = 0;

   int model_count = 0;
   int model_wrap  = 0;

   load_value_counter #(.WIDTH(WIDTH), .RESET_VALUE(0)) dut (
      .Clk              (clk),
      .Rst              (rst),
      .Load_Value_Valid (load_valid),
      .Load_Value       (load_value),
      .Count            (count),
      .Wrap             (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // One edge: apply inputs, advance the model, compare 1 ns after the edge.
   task automatic step(input logic r, input logic lv, input int val, input string tag);
      rst        = r;
      load_valid = lv;
      load_value = WIDTH'(val);
      @(posedge clk);
      if (r) begin
         model_count = 0;
         model_wrap  = 0;
      end else if (lv) begin
         model_count = val % MOD;
         model_wrap  = 0;
      end else begin
         model_wrap  = (model_count == MOD - 1) ? 1 : 0;
         model_count = (model_count + 1) % MOD;
      end
      #1;
      check({tag, ".count"}, int'(count), model_count);
      check({tag, ".wrap"},  int'(wrap),  model_wrap);
      $display("%-10s rst=%0b load=%0b val=%2d -> count=%2d wrap=%0b",
               tag, r, lv, val, count, wrap);
   endtask

   initial begin
      // Reset with a competing load that must be ignored.
      step(1'b1, 1'b1, 10, "reset");
      step(1'b1, 1'b1, 10, "reset");
      check("reset_const", int'(count), 0);

      // Free count through one wrap: 1..15, 0, 1.
      for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 0, "free");

      // Load 10, then run past the wrap.
      step(1'b0, 1'b1, 10, "load10");
      check("load10_const", int'(count), 10);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, "after10");

      // Load 5 while counting.
      step(1'b0, 1'b1, 5, "load5");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, "after5");

      // Reach 15, then load 15: no wrap on the load, wrap on the next increment.
      step(1'b0, 1'b1, 14, "load14");
      step(1'b0, 1'b0, 0,  "to15");
      step(1'b0, 1'b1, 15, "load15");
      check("load15_wrap", int'(wrap), 0);
      step(1'b0, 1'b0, 0,  "wrap15");
      check("wrap15_const", int'(wrap), 1);

      // Held load of 3 for three cycles, then release.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3, "hold3");
      step(1'b0, 1'b0, 0, "rel3");
      check("rel3_const", int'(count), 4);

      // Reset mid-operation at 9 with a load pending.
      step(1'b0, 1'b1, 8, "load8");
      step(1'b0, 1'b0, 0, "to9");
      step(1'b1, 1'b1, 12, "rst_mid");
      step(1'b0, 1'b0, 0, "post_rst");
      step(1'b0, 1'b0, 0, "post_rst");

      // Random traffic with occasional loads (often all-ones) and resets.
      for (int i = 0; i < 400; i++) begin
         logic r, lv;
         int   v;
         r  = ($urandom_range(0, 99) < 3);
         lv = ($urandom_range(0, 99) < 20);
         v  = ($urandom_range(0, 3) == 0) ? MOD - 1 : int'($urandom_range(0, MOD - 1));
         step(r, lv, v, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
